pipe_reg_skid: RTL and testbench

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/pipe_reg_pkg.sv | 21 ++
 rtl/pipe_reg_slot.sv | 38 +++
 rtl/pipe_reg_skid.sv | 133 +++++++++++++
 tb/tb_pipe_reg_skid.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared types and helpers for the pipe_reg_skid two-entry skid buffer.
package pipe_reg_pkg;

  typedef enum logic [1:0] {
    PR_EMPTY = 2'd0,
    PR_ONE   = 2'd1,
    PR_TWO   = 2'd2
  } pr_state_e;

  // Widest stall counter the saturation helper supports.
  localparam int unsigned PR_CNT_MAX_W = 64;

  // True when a w-bit counter (zero-extended into cnt) sits at its ceiling.
  function automatic logic pr_cnt_at_max(input logic [PR_CNT_MAX_W-1:0] cnt,
                                         input int unsigned w);
    logic [PR_CNT_MAX_W-1:0] max_val;
    max_val = (w >= PR_CNT_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    return (cnt >= max_val);
  endfunction

endpackage

// File: rtl/pipe_reg_slot.sv
// WIDTH-bit data slot with load enable; reset and clear both restore RESET_VAL.
module pipe_reg_slot
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
)
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (i_clr) begin
      data_d = RESET_VAL;
    end else if (i_en) begin
      data_d = i_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_q = data_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Two-entry skid buffer: registered valid/ready with full throughput.
// Optional stall counter built only when PIPE_REG_STALL_CNT_EN is defined.
module pipe_reg_skid
  import pipe_reg_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int                CNT_W     = 16
)
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cnt
);

  pr_state_e        state_q;
  pr_state_e        state_d;
  logic             accept;
  logic             pop;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign o_valid = (state_q != PR_EMPTY);
  assign o_ready = (state_q != PR_TWO);
  assign accept  = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (i_flush) begin
      // Slots are cleared through their own clear inputs.
      state_d = PR_EMPTY;
    end else begin
      case (state_q)
        PR_EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            state_d = PR_ONE;
          end
        end
        PR_ONE: begin
          if (accept && pop) begin
            main_en = 1'b1;
          end else if (accept) begin
            skid_en = 1'b1;
            state_d = PR_TWO;
          end else if (pop) begin
            state_d = PR_EMPTY;
          end
        end
        PR_TWO: begin
          if (pop) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = PR_ONE;
          end
        end
        default: state_d = PR_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= PR_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : i_data;

  pipe_reg_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_flush),
    .i_en    (main_en),
    .i_d     (main_d),
    .o_q     (main_q)
  );

  pipe_reg_slot #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_flush),
    .i_en    (skid_en),
    .i_d     (i_data),
    .o_q     (skid_q)
  );

  assign o_data = main_q;

`ifdef PIPE_REG_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_valid && !i_ready &&
        !pr_cnt_at_max(PR_CNT_MAX_W'(stall_cnt_q), CNT_W)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed scoreboard bench for pipe_reg_skid; stall expectations follow PIPE_REG_STALL_CNT_EN.
module tb_pipe_reg_skid;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 4;
  localparam logic [7:0] RST   = 8'hA5;
`ifdef PIPE_REG_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] i_data = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic             i_flush = 1'b0;
  logic [CNT_W-1:0] o_stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_reg_skid #(.WIDTH(WIDTH), .RESET_VAL(RST), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .i_flush     (i_flush),
    .o_stall_cnt (o_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stall_exp(input int n);
    return STALL_EN ? 32'(n) : 32'd0;
  endfunction

  // Monitor: every transfer the DUT presents is popped and compared in order.
  always @(negedge clk) begin
    if (!i_reset && !i_flush && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected actual=0x%0h expected=<none>", o_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          failures++;
          $display("FAIL pop_data actual=0x%0h expected=0x%0h", o_data, e);
        end else begin
          $display("ok   pop_data value=0x%0h", o_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then idle
    tick(); tick();
    i_reset = 1'b0;
    tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_data",  32'(o_data),  32'(RST));
    chk("rst_stall", 32'(o_stall_cnt), 32'd0);

    // Streaming at full rate
    i_ready = 1'b1;
    i_valid = 1'b1; i_data = 8'h11; exp_q.push_back(8'h11);
    tick();
    chk("lat_valid_11", 32'(o_valid), 32'd1);
    chk("lat_data_11",  32'(o_data),  32'h11);
    i_data = 8'h22; exp_q.push_back(8'h22);
    tick();
    chk("stream_data_22", 32'(o_data), 32'h22);
    chk("stream_ready",   32'(o_ready), 32'd1);
    i_data = 8'h33; exp_q.push_back(8'h33);
    tick();
    chk("stream_data_33", 32'(o_data), 32'h33);
    i_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(o_valid), 32'd0);

    // Back-pressure into the skid slot
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h0A; exp_q.push_back(8'h0A);
    tick();
    i_data = 8'h0B; exp_q.push_back(8'h0B);
    tick();
    chk("skid_ready_low", 32'(o_ready), 32'd0);
    i_data = 8'h0C;
    tick(); tick();
    chk("skid_main_held", 32'(o_data), 32'h0A);
    chk("skid_stall3", 32'(o_stall_cnt), stall_exp(3));
    i_ready = 1'b1;
    tick();
    chk("skid_ready_back", 32'(o_ready), 32'd1);
    chk("skid_main_b", 32'(o_data), 32'h0B);
    exp_q.push_back(8'h0C);
    tick();
    i_valid = 1'b0;
    tick();
    chk("skid_empty", 32'(o_valid), 32'd0);
    chk("skid_stall_kept", 32'(o_stall_cnt), stall_exp(3));

    // Flush from TWO with a competing accept
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h05; exp_q.push_back(8'h05);
    tick();
    i_data = 8'h06; exp_q.push_back(8'h06);
    tick();
    chk("two_ready", 32'(o_ready), 32'd0);
    chk("two_data",  32'(o_data),  32'h05);
    i_flush = 1'b1; i_data = 8'h07; exp_q.delete();
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_ready", 32'(o_ready), 32'd1);
    chk("flush_data",  32'(o_data),  32'(RST));
    chk("flush_stall_kept", 32'(o_stall_cnt), stall_exp(5));
    i_ready = 1'b1;
    tick();
    chk("flush_no_capture", 32'(o_valid), 32'd0);

    // Counter saturation
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h42; exp_q.push_back(8'h42);
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("sat_mid", 32'(o_stall_cnt), stall_exp(10));
    for (int i = 0; i < 15; i++) tick();
    chk("sat_top", 32'(o_stall_cnt), stall_exp(15));
    chk("sat_data_held", 32'(o_data), 32'h42);
    i_ready = 1'b1;
    tick();
    chk("sat_after_drain", 32'(o_stall_cnt), stall_exp(15));

    // Reset and flush together during traffic
    i_valid = 1'b1; i_data = 8'h99; exp_q.push_back(8'h99);
    tick();
    i_reset = 1'b1; i_flush = 1'b1; i_data = 8'h77; exp_q.delete();
    tick();
    i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    chk("rf_valid", 32'(o_valid), 32'd0);
    chk("rf_ready", 32'(o_ready), 32'd1);
    chk("rf_data",  32'(o_data),  32'(RST));
    chk("rf_stall", 32'(o_stall_cnt), 32'd0);
    tick();
    chk("rf_stays_empty", 32'(o_valid), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
